// File: rtl/instr_stream_encoder.sv
// instr_stream_encoder: turns decoded instruction descriptors into 32-bit
// ARM-subset words and writes them to instruction memory at consecutive
// word addresses starting at StartAddr.
//
// Handshake rules: a descriptor transfers on a rising edge where
// InValid & InReady; a memory write completes on a rising edge where
// MemWE & MemReady. While MemWE is high and MemReady is low, MemWE,
// MemAddr and MemWData hold their values.
//
// Optional build macro: ERR_ABORT_EN. When it is defined, an illegal
// descriptor ends the program: nothing is written for it, and the rest of
// the program is drained. When it is undefined, NOP_WORD is written in
// place of the illegal descriptor and the stream carries on.
module instr_stream_encoder #(
  parameter int          AW       = 8,
  parameter logic [31:0] NOP_WORD = 32'hE1A00000
) (
  input  logic          CLK,
  input  logic          nRESET,
  input  logic          Start,
  input  logic [AW-1:0] StartAddr,
  input  logic          InValid,
  output logic          InReady,
  input  logic          InLast,
  input  logic [2:0]    InCode,
  input  logic [1:0]    InCond,
  input  logic          InImmSel,
  input  logic          InS,
  input  logic          InUp,
  input  logic [3:0]    InRd,
  input  logic [3:0]    InRn,
  input  logic [3:0]    InRm,
  input  logic [11:0]   InImm,
  input  logic [23:0]   InOff,
  output logic          MemWE,
  input  logic          MemReady,
  output logic [AW-1:0] MemAddr,
  output logic [31:0]   MemWData,
  output logic          Busy,
  output logic          Done,
  output logic [AW:0]   Count,
  output logic          Error,
  output logic [1:0]    DbgState
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] FLUSH  = 2'd2;
`ifdef ERR_ABORT_EN
  localparam logic [1:0] DRAIN  = 2'd3;
`endif

  logic [1:0]    state_q, state_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [AW-1:0] nxt_q, nxt_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          done_q, done_d;

  logic [3:0]    cond4;
  logic [11:0]   src2;
  logic [31:0]   enc_word;
  logic          illegal;
  logic          accept;
  logic          wr_done;

  // Encode the descriptor currently on the input bus.
  always_comb begin
    illegal  = (InCond == 2'b11);
    src2     = InImmSel ? InImm : {8'b0, InRm};
    cond4    = 4'b1110;
    enc_word = NOP_WORD;
    case (InCond)
      2'b00:   cond4 = 4'b1110;
      2'b01:   cond4 = 4'b0000;
      2'b10:   cond4 = 4'b0001;
      default: cond4 = 4'b1110;
    endcase
    case (InCode)
      3'b000: enc_word = {cond4, 2'b00, InImmSel, 4'b0100, InS, InRn, InRd, src2};
      3'b001: enc_word = {cond4, 2'b00, InImmSel, 4'b0010, InS, InRn, InRd, src2};
      3'b010: enc_word = {cond4, 2'b00, InImmSel, 4'b1101, InS, 4'b0000, InRd, src2};
      3'b011: enc_word = {cond4, 2'b00, InImmSel, 4'b1010, 1'b1, InRn, 4'b0000, src2};
      3'b100: enc_word = {cond4, 2'b01, ~InImmSel, 1'b1, InUp, 2'b00, 1'b0, InRn, InRd, src2};
      3'b101: enc_word = {cond4, 2'b01, ~InImmSel, 1'b1, InUp, 2'b00, 1'b1, InRn, InRd, src2};
      3'b110: enc_word = {cond4, 3'b101, 1'b0, InOff};
      default: enc_word = {cond4, 3'b101, 1'b1, InOff};
    endcase
  end

  // Ready when streaming and the output register is free or emptying now;
  // while draining, everything offered is swallowed.
  always_comb begin
    InReady = (state_q == STREAM) & (~we_q | MemReady);
`ifdef ERR_ABORT_EN
    if (state_q == DRAIN) InReady = 1'b1;
`endif
  end

  assign accept  = InValid & InReady;
  assign wr_done = we_q & MemReady;

  // Next-state logic for the FSM, output register and counters.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    nxt_d   = nxt_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    done_d  = 1'b0;
    if (wr_done) begin
      we_d = 1'b0;
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = STREAM;
          nxt_d   = StartAddr;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      STREAM: begin
        if (accept) begin
          if (illegal) err_d = 1'b1;
`ifdef ERR_ABORT_EN
          if (illegal) begin
            state_d = InLast ? FLUSH : DRAIN;
          end else begin
            we_d    = 1'b1;
            addr_d  = nxt_q;
            wdata_d = enc_word;
            nxt_d   = nxt_q + 1'b1;
            if (InLast) state_d = FLUSH;
          end
`else
          we_d    = 1'b1;
          addr_d  = nxt_q;
          wdata_d = illegal ? NOP_WORD : enc_word;
          nxt_d   = nxt_q + 1'b1;
          if (InLast) state_d = FLUSH;
`endif
        end
      end
      FLUSH: begin
        if (~we_q | MemReady) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
`ifdef ERR_ABORT_EN
      DRAIN: begin
        if (accept & InLast) state_d = FLUSH;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops any pending write.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      nxt_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      nxt_q   <= nxt_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign MemWE    = we_q;
  assign MemAddr  = addr_q;
  assign MemWData = wdata_q;
  assign Busy     = (state_q != IDLE);
  assign Done     = done_q;
  assign Count    = cnt_q;
  assign Error    = err_q;
  assign DbgState = state_q;

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Testbench for instr_stream_encoder: spec vector table, hand-written
// stall / wrap / reset sequences, and randomized programs checked against
// a field-level reference encoder and an address/count model.
module tb_instr_stream_encoder;
  localparam int AW = 8;
  localparam logic [31:0] NOP = 32'hE1A00000;
  localparam int CNT_MAX = (1 << (AW + 1)) - 1;

  typedef struct {
    logic [2:0]  code;
    logic [1:0]  cond;
    logic        immsel;
    logic        s;
    logic        up;
    logic [3:0]  rd;
    logic [3:0]  rn;
    logic [3:0]  rm;
    logic [11:0] imm;
    logic [23:0] off;
  } desc_t;

  typedef struct {
    desc_t       d;
    logic [31:0] exp;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic CLK = 1'b0;
  logic nRESET;
  logic Start;
  logic [AW-1:0] StartAddr;
  logic InValid, InReady, InLast;
  logic [2:0] InCode;
  logic [1:0] InCond;
  logic InImmSel, InS, InUp;
  logic [3:0] InRd, InRn, InRm;
  logic [11:0] InImm;
  logic [23:0] InOff;
  logic MemWE, MemReady;
  logic [AW-1:0] MemAddr;
  logic [31:0] MemWData;
  logic Busy, Done, Error;
  logic [AW:0] Count;
  logic [1:0] DbgState;

  always #5 CLK = ~CLK;

  instr_stream_encoder #(.AW(AW), .NOP_WORD(NOP)) dut (
    .CLK(CLK), .nRESET(nRESET), .Start(Start), .StartAddr(StartAddr),
    .InValid(InValid), .InReady(InReady), .InLast(InLast), .InCode(InCode),
    .InCond(InCond), .InImmSel(InImmSel), .InS(InS), .InUp(InUp),
    .InRd(InRd), .InRn(InRn), .InRm(InRm), .InImm(InImm), .InOff(InOff),
    .MemWE(MemWE), .MemReady(MemReady), .MemAddr(MemAddr),
    .MemWData(MemWData), .Busy(Busy), .Done(Done), .Count(Count),
    .Error(Error), .DbgState(DbgState)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // MemReady source: 0 = always ready, 1 = stalled, 2 = random.
  int ready_mode = 0;
  initial begin
    MemReady = 1'b1;
    forever begin
      @(posedge CLK);
      #2;
      case (ready_mode)
        0: MemReady = 1'b1;
        1: MemReady = 1'b0;
        default: MemReady = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [AW+31:0] exp_q[$];
  logic [AW-1:0] m_addr;
  int m_nw;
  bit m_err, m_abort;

  function automatic logic [31:0] ref_word(input desc_t d);
    int unsigned c, op, i, s, u, l, rn, rd, src2, w;
    c    = (d.cond == 2'd0) ? 14 : (d.cond == 2'd1) ? 0 : 1;
    i    = 32'(d.immsel);
    src2 = d.immsel ? 32'(d.imm) : 32'(d.rm);
    rn   = 32'(d.rn);
    rd   = 32'(d.rd);
    s    = 32'(d.s);
    u    = 32'(d.up);
    case (d.code)
      3'd0, 3'd1, 3'd2, 3'd3: begin
        op = (d.code == 3'd0) ? 4 : (d.code == 3'd1) ? 2 : (d.code == 3'd2) ? 13 : 10;
        if (d.code == 3'd2) rn = 0;
        if (d.code == 3'd3) begin rd = 0; s = 1; end
        w = c * (2**28) + i * (2**25) + op * (2**21) + s * (2**20)
            + rn * (2**16) + rd * (2**12) + src2;
      end
      3'd4, 3'd5: begin
        l = (d.code == 3'd5) ? 1 : 0;
        w = c * (2**28) + 1 * (2**26) + (1 - i) * (2**25) + 1 * (2**24)
            + u * (2**23) + l * (2**20) + rn * (2**16) + rd * (2**12) + src2;
      end
      default: begin
        l = (d.code == 3'd7) ? 1 : 0;
        w = c * (2**28) + 5 * (2**25) + l * (2**24) + 32'(d.off);
      end
    endcase
    return w;
  endfunction

  task automatic model_start(input logic [AW-1:0] a);
    m_addr  = a;
    m_nw    = 0;
    m_err   = 1'b0;
    m_abort = 1'b0;
  endtask

  task automatic model_push(input desc_t d, input logic [31:0] word);
    if (m_abort) return;
    if (d.cond == 2'd3) begin
      m_err = 1'b1;
`ifdef ERR_ABORT_EN
      m_abort = 1'b1;
      return;
`else
      word = NOP;
`endif
    end
    exp_q.push_back({m_addr, word});
    m_addr = m_addr + 1'b1;
    m_nw++;
  endtask

  // ---------------- write monitor / scoreboard ----------------
  int wr_cnt = 0, last_wr_cyc = 0, mark_cnt = 0, mark_cyc = 0;
  always @(negedge CLK) begin
    logic [AW+31:0] e;
    if (nRESET && MemWE && MemReady) begin
      if (wr_cnt == mark_cnt) mark_cyc = cyc;
      wr_cnt++;
      last_wr_cyc = cyc;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr %0h data %0h, required none", MemAddr, MemWData);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'(MemAddr), 64'(e[AW+31:32]));
        chk("wr_data", 64'(MemWData), 64'(e[31:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic desc_t mk(input logic [2:0] code, input logic [1:0] cond,
                               input logic immsel, input logic s, input logic up,
                               input logic [3:0] rd, input logic [3:0] rn,
                               input logic [3:0] rm, input logic [11:0] imm,
                               input logic [23:0] off);
    desc_t d;
    d.code = code; d.cond = cond; d.immsel = immsel; d.s = s; d.up = up;
    d.rd = rd; d.rn = rn; d.rm = rm; d.imm = imm; d.off = off;
    return d;
  endfunction

  function automatic desc_t rand_desc(input bit allow_illegal);
    desc_t d;
    d.code   = 3'($urandom_range(0, 7));
    d.cond   = (allow_illegal && $urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    d.immsel = 1'($urandom_range(0, 1));
    d.s      = 1'($urandom_range(0, 1));
    d.up     = 1'($urandom_range(0, 1));
    d.rd     = 4'($urandom_range(0, 15));
    d.rn     = 4'($urandom_range(0, 15));
    d.rm     = 4'($urandom_range(0, 15));
    d.imm    = 12'($urandom_range(0, 4095));
    d.off    = 24'($urandom());
    return d;
  endfunction

  task automatic drive(input desc_t d, input bit last);
    InCode = d.code; InCond = d.cond; InImmSel = d.immsel; InS = d.s; InUp = d.up;
    InRd = d.rd; InRn = d.rn; InRm = d.rm; InImm = d.imm; InOff = d.off;
    InLast = last;
    InValid = 1'b1;
  endtask

  task automatic wait_accept(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (InReady) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got InReady=0 for 200 cycles, required 1");
    end
    @(posedge CLK);
    #1;
    InValid = 1'b0;
    InLast  = 1'b0;
  endtask

  task automatic send(input desc_t d, input bit last, input logic [31:0] word);
    bit ok;
    drive(d, last);
    wait_accept(ok);
    if (ok) model_push(d, word);
  endtask

  task automatic do_start(input logic [AW-1:0] a);
    @(posedge CLK);
    #1;
    Start = 1'b1;
    StartAddr = a;
    @(posedge CLK);
    #1;
    Start = 1'b0;
    model_start(a);
    mark_cnt = wr_cnt;
  endtask

  task automatic wait_done(input bit chk_lat);
    bit found;
    int exp_cnt;
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (Done) begin found = 1'b1; break; end
    end
    chk("done_seen", 64'(found), 64'd1);
    exp_cnt = (m_nw > CNT_MAX) ? CNT_MAX : m_nw;
    if (found) begin
      if (chk_lat) chk("done_latency", 64'(cyc - last_wr_cyc), 64'd1);
      chk("done_count", 64'(Count), 64'(exp_cnt));
      chk("done_error", 64'(Error), 64'(m_err));
      chk("done_busy", 64'(Busy), 64'd0);
      chk("sb_empty", 64'(exp_q.size()), 64'd0);
      @(negedge CLK);
      chk("done_pulse", 64'(Done), 64'd0);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_inready", 64'(InReady), 64'd0);
    chk("rst_memwe", 64'(MemWE), 64'd0);
    chk("rst_memaddr", 64'(MemAddr), 64'd0);
    chk("rst_memwdata", 64'(MemWData), 64'd0);
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_done", 64'(Done), 64'd0);
    chk("rst_count", 64'(Count), 64'd0);
    chk("rst_error", 64'(Error), 64'd0);
    chk("rst_state", 64'(DbgState), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    vec_t vecs[6];
    desc_t da, db;
    bit ok, lat;
    int base, n;

    vecs[0].d = mk(3'd1, 2'd0, 1'b0, 1'b1, 1'b0, 4'd3, 4'd4, 4'd5, 12'h000, 24'h0);
    vecs[0].exp = 32'hE0543005;
    vecs[1].d = mk(3'd3, 2'd1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd1, 4'd0, 12'h000, 24'h0);
    vecs[1].exp = 32'h03510000;
    vecs[2].d = mk(3'd5, 2'd0, 1'b1, 1'b0, 1'b1, 4'd2, 4'd0, 4'd0, 12'h008, 24'h0);
    vecs[2].exp = 32'hE5902008;
    vecs[3].d = mk(3'd4, 2'd0, 1'b1, 1'b0, 1'b1, 4'd2, 4'd0, 4'd0, 12'h004, 24'h0);
    vecs[3].exp = 32'hE5802004;
    vecs[4].d = mk(3'd7, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 12'h000, 24'h000010);
    vecs[4].exp = 32'hEB000010;
    vecs[5].d = mk(3'd6, 2'd2, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 12'h000, 24'hFFFFFE);
    vecs[5].exp = 32'h1AFFFFFE;

    nRESET = 1'b0; Start = 1'b0; StartAddr = '0; InValid = 1'b0; InLast = 1'b0;
    drive(mk(3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 12'h0, 24'h0), 1'b0);
    InValid = 1'b0;
    #23;
    chk_reset_outputs();
    @(posedge CLK);
    #1;
    nRESET = 1'b1;

    // Single ADD immediate at 0x10.
    do_start(8'h10);
    send(mk(3'd0, 2'd0, 1'b1, 1'b0, 1'b0, 4'd1, 4'd2, 4'd0, 12'h005, 24'h0), 1'b1, 32'hE2821005);
    wait_done(1'b1);

    // Table vectors back-to-back; a Start pulse mid-stream must be ignored.
    do_start(8'h20);
    for (int i = 0; i < 6; i++) begin
      if (i == 1) begin Start = 1'b1; StartAddr = 8'h80; end
      send(vecs[i].d, (i == 5), vecs[i].exp);
      Start = 1'b0;
    end
    wait_done(1'b1);
    chk("no_bubbles", 64'(last_wr_cyc - mark_cyc), 64'd5);

    // Memory stall for 3 cycles while a second descriptor waits.
    ready_mode = 1;
    do_start(8'h30);
    da = rand_desc(1'b0);
    db = rand_desc(1'b0);
    send(da, 1'b0, ref_word(da));
    base = wr_cnt;
    drive(db, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("stall_inready", 64'(InReady), 64'd0);
      chk("stall_memwe", 64'(MemWE), 64'd1);
      chk("stall_addr", 64'(MemAddr), 64'h30);
      chk("stall_data", 64'(MemWData), 64'(ref_word(da)));
      chk("stall_no_write", 64'(wr_cnt - base), 64'd0);
    end
    @(posedge CLK);
    #1;
    ready_mode = 0;
    wait_accept(ok);
    if (ok) model_push(db, ref_word(db));
    wait_done(1'b1);
    chk("stall_writes", 64'(wr_cnt - base), 64'd2);

    // Address wrap from the top of memory.
    do_start(8'hFF);
    da = rand_desc(1'b0);
    send(da, 1'b0, ref_word(da));
    da = rand_desc(1'b0);
    send(da, 1'b1, ref_word(da));
    wait_done(1'b1);

    // Illegal condition in the middle of a program.
    do_start(8'h40);
    da = rand_desc(1'b0);
    send(da, 1'b0, ref_word(da));
    da = rand_desc(1'b0);
    da.cond = 2'd3;
    send(da, 1'b0, ref_word(da));
    for (int i = 0; i < 2; i++) begin
      da = rand_desc(1'b0);
      send(da, (i == 1), ref_word(da));
    end
`ifdef ERR_ABORT_EN
    wait_done(1'b0);
`else
    wait_done(1'b1);
`endif

    // Randomized programs with random memory backpressure and input gaps.
    ready_mode = 2;
    for (int p = 0; p < 20; p++) begin
      do_start(8'($urandom_range(0, 255)));
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
        da = rand_desc(1'b1);
        send(da, (i == n - 1), ref_word(da));
      end
      lat = !m_abort;
      wait_done(lat);
    end
    ready_mode = 0;

    // Count saturation over a long program.
    do_start(8'h00);
    for (int i = 0; i < CNT_MAX + 4; i++) begin
      da = rand_desc(1'b0);
      send(da, (i == CNT_MAX + 3), ref_word(da));
    end
    wait_done(1'b1);

    // Asynchronous reset while a write is stalled.
    ready_mode = 1;
    do_start(8'h50);
    da = rand_desc(1'b0);
    send(da, 1'b0, ref_word(da));
    @(negedge CLK);
    chk("pre_reset_memwe", 64'(MemWE), 64'd1);
    #2;
    nRESET = 1'b0;
    #1;
    chk_reset_outputs();
    exp_q.delete();
    @(posedge CLK);
    #3;
    nRESET = 1'b1;
    ready_mode = 0;
    @(negedge CLK);
    chk("post_reset_memwe", 64'(MemWE), 64'd0);
    chk("post_reset_busy", 64'(Busy), 64'd0);

    // Recovery after reset.
    do_start(8'h60);
    da = rand_desc(1'b0);
    send(da, 1'b1, ref_word(da));
    wait_done(1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
